// File: rtl/fixed_point_accumulator_pkg.sv
// Shared types and constants for the fixed-point accumulator.
// Provides the FSM state enum, the width constants and the saturation limits
// for the A-bit accumulator and the N-bit result.
package fxp_pkg;

  localparam int unsigned Q  = 8;      // fractional bits, format tag only
  localparam int unsigned N  = 16;     // sample / result width
  localparam int unsigned G  = 4;      // accumulator guard bits
  localparam int unsigned A  = N + G;  // accumulator width
  localparam int unsigned CW = 8;      // beat counter width

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_e;

  // Largest positive accumulator value: 2^(A-1)-1
  function automatic logic [A-1:0] acc_max();
    return {1'b0, {(A-1){1'b1}}};
  endfunction

  // Most negative accumulator value: -2^(A-1)
  function automatic logic [A-1:0] acc_min();
    return {1'b1, {(A-1){1'b0}}};
  endfunction

  // Largest positive result value: 2^(N-1)-1
  function automatic logic [N-1:0] res_max();
    return {1'b0, {(N-1){1'b1}}};
  endfunction

  // Most negative result value: -2^(N-1)
  function automatic logic [N-1:0] res_min();
    return {1'b1, {(N-1){1'b0}}};
  endfunction

endpackage

// File: rtl/fixed_point_accumulator_if.sv
// Sample-in / result-out stream bundle of the fixed-point accumulator.
// Input stream: in_valid, in_ready, in_data (N, signed), in_last.
// Output stream: out_valid, out_ready, out_data (N, signed), out_overflow,
// out_count (CW). master = producer/consumer side, slave = accumulator side.
interface fixed_point_accumulator_if;
  import fxp_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          out_overflow;
  logic [CW-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_overflow, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_overflow, out_count
  );

endinterface

// File: rtl/fixed_point_sat_adder.sv
// Combinational saturating adder for A-bit signed operands.
// Ports: a_i, b_i (A-bit signed operands), sum_o (clamped A-bit sum),
// sat_o (high when the true sum fell outside the A-bit range).
module fixed_point_sat_adder
  import fxp_pkg::*;
(
  input  logic [A-1:0] a_i,
  input  logic [A-1:0] b_i,
  output logic [A-1:0] sum_o,
  output logic         sat_o
);

  logic [A:0] wide;

  // One extra bit holds the exact sum; overflow shows as disagreeing top bits
  always_comb begin
    wide  = {a_i[A-1], a_i} + {b_i[A-1], b_i};
    sat_o = wide[A] ^ wide[A-1];
    if (!sat_o) begin
      sum_o = wide[A-1:0];
    end else if (wide[A]) begin
      sum_o = acc_min();
    end else begin
      sum_o = acc_max();
    end
  end

endmodule

// File: rtl/fixed_point_accumulator.sv
// Streaming signed fixed-point accumulator.
// Sums a packet of N-bit samples in an A-bit saturating accumulator and, one
// cycle after the last beat, presents the sum clamped to N bits together with
// an overflow flag and the beat count (mod 2^CW).
// Ports: clk, rst_n (async, active-low), bus (slave side of the stream bundle).
module fixed_point_accumulator
  import fxp_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  fixed_point_accumulator_if.slave bus
);

  state_e        state_q, state_d;
  logic [A-1:0]  acc_q, acc_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic          out_overflow_q, out_overflow_d;
  logic [CW-1:0] out_count_q, out_count_d;

  logic [A-1:0]  sample_ext;
  logic [A-1:0]  add_sum;
  logic          add_sat;
  logic          res_fits;
  logic [N-1:0]  res_narrow;
  logic          beat;

  assign sample_ext = {{G{bus.in_data[N-1]}}, bus.in_data};

  fixed_point_sat_adder u_add (
    .a_i   (acc_q),
    .b_i   (sample_ext),
    .sum_o (add_sum),
    .sat_o (add_sat)
  );

  // Result fits in N bits when every bit above the N-bit sign bit matches it
  always_comb begin
    res_fits = (&add_sum[A-1:N-1]) | ~(|add_sum[A-1:N-1]);
    if (res_fits) begin
      res_narrow = add_sum[N-1:0];
    end else if (add_sum[A-1]) begin
      res_narrow = res_min();
    end else begin
      res_narrow = res_max();
    end
  end

  // in_ready_q is low for the first cycle after reset release
  assign beat = bus.in_valid & in_ready_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ACC;
      acc_q          <= '0;
      ovf_q          <= 1'b0;
      cnt_q          <= '0;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_overflow_q <= 1'b0;
      out_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      ovf_q          <= ovf_d;
      cnt_q          <= cnt_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_overflow_q <= out_overflow_d;
      out_count_q    <= out_count_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    ovf_d          = ovf_q;
    cnt_d          = cnt_q;
    in_ready_d     = in_ready_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_overflow_d = out_overflow_q;
    out_count_d    = out_count_q;

    case (state_q)
      ACC: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (beat) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_sat;
          cnt_d = cnt_q + CW'(1);
          if (bus.in_last) begin
            ovf_d          = ovf_q | add_sat | ~res_fits;
            out_data_d     = res_narrow;
            out_overflow_d = ovf_q | add_sat | ~res_fits;
            out_count_d    = cnt_q + CW'(1);
            state_d        = OUT;
            in_ready_d     = 1'b0;
            out_valid_d    = 1'b1;
          end
        end
      end
      OUT: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
        if (bus.out_ready) begin
          acc_d       = '0;
          ovf_d       = 1'b0;
          cnt_d       = '0;
          state_d     = ACC;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_overflow = out_overflow_q;
  assign bus.out_count    = out_count_q;

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Self-checking bench for fixed_point_accumulator: a reference model pushes the
// expected packet result when the last beat is driven, and the receive task
// pops and compares it when the DUT presents out_valid.
module tb_fixed_point_accumulator;
  import fxp_pkg::*;

  typedef struct {
    logic [15:0] data;
    logic        ovf;
    logic [7:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  int m_acc = 0;
  bit m_ovf = 1'b0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  fixed_point_accumulator_if bus ();

  fixed_point_accumulator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic model_clear();
    m_acc = 0;
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  // Reference: 20-bit saturating accumulate, 16-bit final clamp
  task automatic model_beat(input logic [15:0] d, input bit last);
    int   s;
    int   r;
    exp_t e;
    s = m_acc + int'($signed(d));
    if (s > 524287) begin s = 524287; m_ovf = 1'b1; end
    if (s < -524288) begin s = -524288; m_ovf = 1'b1; end
    m_acc = s;
    m_cnt = m_cnt + 1;
    if (last) begin
      r = s;
      if (r > 32767) begin r = 32767; m_ovf = 1'b1; end
      if (r < -32768) begin r = -32768; m_ovf = 1'b1; end
      e.data = 16'(r);
      e.ovf  = m_ovf;
      e.cnt  = 8'(m_cnt);
      sb.push_back(e);
      model_clear();
    end
  endtask

  // Drive one beat; returns at posedge+1 after it was accepted
  task automatic drive_beat(input logic [15:0] d, input bit last);
    int budget = 50;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (!bus.in_ready) begin
      total++; bad++;
      $display("FAIL beat_accept: in_ready never rose (actual 0, required 1)");
    end else begin
      @(posedge clk); #1;
      model_beat(d, last);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_const(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) drive_beat(d, (i == n - 1));
  endtask

  // Wait for a result, compare it with the scoreboard, then handshake
  task automatic recv_check(input string name);
    int   budget = 50;
    exp_t e;
    while (!bus.out_valid && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    total++;
    if (!bus.out_valid) begin
      bad++;
      $display("FAIL %s_valid: out_valid=%0b required 1", name, bus.out_valid);
      return;
    end
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s_sb: unexpected result, scoreboard size 0 required >0", name);
      return;
    end
    e = sb.pop_front();
    total++;
    if (bus.out_data !== e.data) begin
      bad++;
      $display("FAIL %s_data: got %h required %h", name, bus.out_data, e.data);
    end
    total++;
    if (bus.out_overflow !== e.ovf) begin
      bad++;
      $display("FAIL %s_ovf: got %b required %b", name, bus.out_overflow, e.ovf);
    end
    total++;
    if (bus.out_count !== e.cnt) begin
      bad++;
      $display("FAIL %s_count: got %0d required %0d", name, bus.out_count, e.cnt);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_release: in_ready=%b out_valid=%b required 1/0",
               name, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_data !== 16'h0 ||
        bus.out_overflow !== 1'b0 || bus.out_count !== 8'h0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b ready=%b data=%h ovf=%b cnt=%0d required 0/0/0000/0/0",
               bus.out_valid, bus.in_ready, bus.out_data, bus.out_overflow, bus.out_count);
    end
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: in_ready=%b required 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    drive_beat(16'h0180, 1'b0);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_early_valid: out_valid=%b required 0", bus.out_valid);
    end
    drive_beat(16'h0240, 1'b1);
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL basic_latency: out_valid=%b required 1", bus.out_valid);
    end
    recv_check("basic");
  endtask

  task automatic test_saturation();
    send_const(16'h7FFF, 16);
    recv_check("sat_pos");
    drive_beat(16'h8000, 1'b0);
    drive_beat(16'h8000, 1'b1);
    recv_check("sat_neg");
    drive_beat(16'h0100, 1'b0);
    drive_beat(16'hFF00, 1'b1);
    recv_check("zero");
  endtask

  task automatic test_stall();
    drive_beat(16'h0123, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h7777;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 16'h0123 ||
          bus.out_overflow !== 1'b0 || bus.out_count !== 8'd1) begin
        bad++;
        $display("FAIL stall_hold%0d: ready=%b valid=%b data=%h ovf=%b cnt=%0d required 0/1/0123/0/1",
                 i, bus.in_ready, bus.out_valid, bus.out_data, bus.out_overflow, bus.out_count);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    recv_check("stall");
    drive_beat(16'h0005, 1'b1);
    recv_check("after_stall");
  endtask

  task automatic test_single_and_wrap();
    drive_beat(16'hFE80, 1'b1);
    recv_check("single");
    send_const(16'h0001, 256);
    recv_check("wrap");
  endtask

  task automatic test_reset_mid();
    send_const(16'h1000, 3);
    // the three beats above ended with last=1; rebuild an unterminated packet
    recv_check("pre_abort");
    drive_beat(16'h1000, 1'b0);
    drive_beat(16'h2000, 1'b0);
    drive_beat(16'h3000, 1'b0);
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_reset: valid=%b ready=%b required 0/0", bus.out_valid, bus.in_ready);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    drive_beat(16'h0010, 1'b1);
    recv_check("post_abort");
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 6; p++) begin
      int n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        drive_beat(16'($urandom()), (i == n - 1));
      end
      recv_check("random");
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_stall();
    test_single_and_wrap();
    test_reset_mid();
    test_back_to_back();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d results outstanding, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
